// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and helpers for the FIR output chain
package fir_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FIR_TAPS = 19;
  localparam int WARMUP_DEF = FIR_TAPS + 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with explicit level counter; a pop frees a slot for a same-edge push
module sync_fifo import fir_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic [clog2(DEPTH):0] level_o
);
  localparam int AW = clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign valid_o = level_q != '0;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;
  // pointer and occupancy next state
  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    level_d = (do_push && !do_pop) ? level_q + (AW+1)'(1) :
              (!do_push && do_pop) ? level_q - (AW+1)'(1) : level_q;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  // sample storage; contents are don't-care until the level says otherwise
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: drops FIR warm-up samples, decimates, and buffers kept samples for a consumer
module fir_decim_buffer import fir_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  warm
);
  localparam int WW = clog2(WARMUP + 1);
  localparam int DW = clog2(DECIM + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic warm_q, warm_d, ovf_q, ovf_d;
  logic keep, full, pop;
  assign pop      = out_valid && out_ready;
  assign keep     = in_en && warm_q && dcnt_q == '0;
  assign warm     = warm_q;
  assign overflow = ovf_q;
  // warm-up, decimation and overflow next state; a drop wins over a clear
  always_comb begin
    wcnt_d = (in_en && !warm_q) ? wcnt_q + WW'(1) : wcnt_q;
    warm_d = warm_q || (in_en && wcnt_q == WW'(WARMUP - 1));
    dcnt_d = (in_en && warm_q) ? (dcnt_q == DW'(DECIM - 1) ? '0 : dcnt_q + DW'(1)) : dcnt_q;
    ovf_d  = (keep && full && !pop) || (ovf_q && !clr_ovf);
  end
  // control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      dcnt_q <= '0;
      warm_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      dcnt_q <= dcnt_d;
      warm_q <= warm_d;
      ovf_q  <= ovf_d;
    end
  end
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (keep),
    .pop_i   (pop),
    .data_i  (in_data),
    .data_o  (out_data),
    .valid_o (out_valid),
    .full_o  (full),
    .level_o (level)
  );
endmodule
